// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - note-event word layout, wave-type codes and packing helper
package wave_pkg;

    localparam int NUM_BTN = 25;
    localparam int BTN_W   = 5;
    localparam int SET_W   = 6;
    localparam int TIME_W  = 20;
    localparam int EVT_W   = 33;

    // Bit positions inside the 33-bit event word
    localparam int EVT_IS_WAVE  = 32;
    localparam int EVT_ONOFF    = 31;
    localparam int EVT_WAVE_LSB = 29;
    localparam int EVT_VOL_LSB  = 27;
    localparam int EVT_OCT_LSB  = 25;
    localparam int EVT_BTN_LSB  = 20;
    localparam int EVT_TS_LSB   = 0;

    typedef enum logic [1:0] {
        WAVE_SQR = 2'b00,
        WAVE_TRI = 2'b01,
        WAVE_SAW = 2'b10,
        WAVE_SIN = 2'b11
    } wave_t;

    typedef struct packed {
        logic              is_wave;
        logic              on_off;
        logic [1:0]        wave;
        logic [1:0]        vol;
        logic [1:0]        oct;
        logic [BTN_W-1:0]  btn_id;
        logic [TIME_W-1:0] tstamp;
    } note_evt_t;

    // Place each field at its documented bus position
    function automatic logic [EVT_W-1:0] pack_evt(input note_evt_t e);
        logic [EVT_W-1:0] w;
        w                          = '0;
        w[EVT_IS_WAVE]             = e.is_wave;
        w[EVT_ONOFF]               = e.on_off;
        w[EVT_WAVE_LSB +: 2]       = e.wave;
        w[EVT_VOL_LSB +: 2]        = e.vol;
        w[EVT_OCT_LSB +: 2]        = e.oct;
        w[EVT_BTN_LSB +: BTN_W]    = e.btn_id;
        w[EVT_TS_LSB +: TIME_W]    = e.tstamp;
        return w;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// rtl/event_fifo.sv - DEPTH-entry event FIFO with registered head and valid/ready output
module event_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 33
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [W-1:0] s_tdata,
    input  logic         s_tvalid,
    output logic         s_tready,
    output logic [W-1:0] m_tdata,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic [AW:0]  count;
    logic         push;
    logic         pop;
    logic         load;

    // count includes the word sitting in the head register, so full means DEPTH words owed to the consumer
    assign full     = (count == (AW+1)'(DEPTH));
    assign pop      = m_tvalid && m_tready;
    assign s_tready = !full || pop;
    assign push     = s_tvalid && s_tready;
    assign load     = (!m_tvalid || m_tready) && (wptr != rptr);

    // Storage write; slot contents need no reset because count gates their use
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wptr[AW-1:0]] <= s_tdata;
        end
    end

    // Write pointer and occupancy
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head register: refill when empty or when the current head is accepted
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rptr     <= '0;
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
        end else if (load) begin
            m_tdata  <= mem[rptr[AW-1:0]];
            m_tvalid <= 1'b1;
            rptr     <= rptr + 1'b1;
        end else if (pop) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/note_event_encoder.sv
// rtl/note_event_encoder.sv - scans note-button levels and emits timestamped ON/OFF event words
module note_event_encoder
    import wave_pkg::*;
#(
    parameter int                DEPTH = 8,
    parameter logic [TIME_W-1:0] LEAD  = 20'd4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NUM_BTN-1:0]  i_btn,
    input  logic [1:0]          i_wave,
    input  logic [1:0]          i_vol,
    input  logic [1:0]          i_oct,
    input  logic [TIME_W-1:0]   i_time,
    input  logic                i_panic,
    output logic [EVT_W-1:0]    o_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [NUM_BTN-1:0]  o_held,
    output logic                o_full
);

    logic [NUM_BTN-1:0] btn_m;
    logic [NUM_BTN-1:0] btn_s;
    logic [NUM_BTN-1:0] tgt;
    logic [NUM_BTN-1:0] sent_on;
    logic [NUM_BTN-1:0] mis;
    logic [SET_W-1:0]   set_r [NUM_BTN];
    logic [BTN_W-1:0]   sel_idx;
    logic               sel_on;
    logic [SET_W-1:0]   live_set;
    logic [SET_W-1:0]   evt_set;
    logic               fifo_ready;
    logic               push;
    note_evt_t          evt;
    logic [EVT_W-1:0]   evt_word;

    // Two-flop synchronizer for the asynchronous button levels
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            btn_m <= '0;
            btn_s <= '0;
        end else begin
            btn_m <= i_btn;
            btn_s <= btn_m;
        end
    end

    assign tgt      = i_panic ? '0 : btn_s;
    assign mis      = tgt ^ sent_on;
    assign live_set = {i_wave, i_vol, i_oct};
    assign push     = (|mis) && fifo_ready;
    assign o_held   = sent_on;

    // Lowest-index mismatching button wins; downward loop leaves the smallest index last
    always_comb begin
        sel_idx = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (mis[i]) begin
                sel_idx = BTN_W'(i);
            end
        end
    end

    // OFF words reuse the settings latched at the matching ON so the receiver clears the same slot
    always_comb begin
        sel_on      = tgt[sel_idx];
        evt_set     = sel_on ? live_set : set_r[sel_idx];
        evt.is_wave = 1'b1;
        evt.on_off  = sel_on;
        evt.wave    = evt_set[5:4];
        evt.vol     = evt_set[3:2];
        evt.oct     = evt_set[1:0];
        evt.btn_id  = sel_idx;
        evt.tstamp  = i_time + LEAD;
        evt_word    = pack_evt(evt);
    end

    // Record the emitted level of the serviced button
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sent_on <= '0;
        end else if (push) begin
            sent_on[sel_idx] <= ~sent_on[sel_idx];
        end
    end

    // Latch settings of each ON event for its later OFF
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                set_r[i] <= '0;
            end
        end else if (push && sel_on) begin
            set_r[sel_idx] <= live_set;
        end
    end

    event_fifo #(
        .DEPTH (DEPTH),
        .W     (EVT_W)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .s_tdata  (evt_word),
        .s_tvalid (|mis),
        .s_tready (fifo_ready),
        .m_tdata  (o_data),
        .m_tvalid (o_valid),
        .m_tready (i_ready),
        .full     (o_full)
    );

endmodule

// File: tb/tb_note_event_encoder.sv
// tb/tb_note_event_encoder.sv - directed self-checking bench for note_event_encoder
module tb_note_event_encoder;

    logic        i_clk;
    logic        i_rst_n;
    logic [24:0] i_btn;
    logic [1:0]  i_wave;
    logic [1:0]  i_vol;
    logic [1:0]  i_oct;
    logic [19:0] i_time;
    logic        i_panic;
    logic [32:0] o_data;
    logic        o_valid;
    logic        i_ready;
    logic [24:0] o_held;
    logic        o_full;

    int n_chk  = 0;
    int n_pass = 0;

    note_event_encoder #(
        .DEPTH (8),
        .LEAD  (20'd4)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_btn   (i_btn),
        .i_wave  (i_wave),
        .i_vol   (i_vol),
        .i_oct   (i_oct),
        .i_time  (i_time),
        .i_panic (i_panic),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_held  (o_held),
        .o_full  (o_full)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [32:0] mk(input logic on, input logic [1:0] w, input logic [1:0] v,
                                       input logic [1:0] o, input logic [4:0] id, input logic [19:0] ts);
        return {1'b1, on, w, v, o, id, ts};
    endfunction

    task automatic step();
        @(negedge i_clk);
    endtask

    // Wait (bounded) for a valid word, capture it, then let one edge pass so it is consumed
    task automatic wait_word(output logic [32:0] w, output int waited);
        waited = 0;
        w      = '0;
        while (!o_valid && waited < 40) begin
            @(negedge i_clk);
            waited++;
        end
        if (!o_valid) begin
            chk("word_timeout", {63'd0, o_valid}, 64'd1);
        end else begin
            w = o_data;
        end
        @(negedge i_clk);
    endtask

    logic [32:0] w;
    int          waited;
    int          ids3 [3] = '{0, 7, 24};

    initial begin
        i_rst_n = 1'b0;
        i_btn   = '0;
        i_wave  = 2'd0;
        i_vol   = 2'd0;
        i_oct   = 2'd0;
        i_time  = 20'd0;
        i_panic = 1'b0;
        i_ready = 1'b1;
        repeat (2) step();
        chk("rst_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_data",  {31'd0, o_data}, 64'd0);
        chk("rst_full",  {63'd0, o_full}, 64'd0);
        chk("rst_held",  {39'd0, o_held}, 64'd0);
        i_rst_n = 1'b1;
        step();

        // Single press: latency and word contents
        i_wave = 2'd3; i_vol = 2'd1; i_oct = 2'd2; i_time = 20'd100;
        i_btn[5] = 1'b1;
        repeat (3) step();
        chk("lat_n3_valid", {63'd0, o_valid}, 64'd0);
        step();
        chk("lat_n4_valid", {63'd0, o_valid}, 64'd1);
        chk("on5_word", {31'd0, o_data}, {31'd0, mk(1'b1, 2'd3, 2'd1, 2'd2, 5'd5, 20'd104)});
        chk("on5_held", {63'd0, o_held[5]}, 64'd1);
        step();
        chk("on5_consumed", {63'd0, o_valid}, 64'd0);

        // Settings change while held must not leak into the OFF word
        i_vol = 2'd3; i_wave = 2'd0; i_time = 20'd200;
        step();
        i_btn[5] = 1'b0;
        wait_word(w, waited);
        chk("off5_word", {31'd0, w}, {31'd0, mk(1'b0, 2'd3, 2'd1, 2'd2, 5'd5, 20'd204)});
        chk("off5_held", {39'd0, o_held}, 64'd0);

        // Simultaneous presses come out lowest index first on consecutive cycles
        i_wave = 2'd1; i_vol = 2'd2; i_oct = 2'd0; i_time = 20'd300;
        i_btn = 25'h1000081;
        for (int i = 0; i < 3; i++) begin
            wait_word(w, waited);
            chk("burst_word", {31'd0, w}, {31'd0, mk(1'b1, 2'd1, 2'd2, 2'd0, 5'(ids3[i]), 20'd304)});
            if (i > 0) chk("burst_gap", 64'(waited), 64'd0);
        end

        // Panic releases held notes with their latched settings
        i_time = 20'd400; i_wave = 2'd2; i_vol = 2'd0; i_oct = 2'd1;
        i_panic = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_word(w, waited);
            chk("panic_off", {31'd0, w}, {31'd0, mk(1'b0, 2'd1, 2'd2, 2'd0, 5'(ids3[i]), 20'd404)});
        end
        chk("panic_held", {39'd0, o_held}, 64'd0);
        repeat (5) step();
        chk("panic_quiet", {63'd0, o_valid}, 64'd0);
        i_panic = 1'b0;
        i_time = 20'd500;
        for (int i = 0; i < 3; i++) begin
            wait_word(w, waited);
            chk("repress_on", {31'd0, w}, {31'd0, mk(1'b1, 2'd2, 2'd0, 2'd1, 5'(ids3[i]), 20'd504)});
        end
        chk("repress_held", {39'd0, o_held}, 64'h1000081);
        i_btn = '0;
        for (int i = 0; i < 3; i++) begin
            wait_word(w, waited);
            chk("release_off", {31'd0, w}, {31'd0, mk(1'b0, 2'd2, 2'd0, 2'd1, 5'(ids3[i]), 20'd504)});
        end

        // Backpressure: ten presses into an eight-deep FIFO
        i_ready = 1'b0;
        i_wave = 2'd0; i_vol = 2'd0; i_oct = 2'd0; i_time = 20'd600;
        i_btn = 25'h0155554;
        repeat (16) step();
        chk("bp_full",  {63'd0, o_full}, 64'd1);
        chk("bp_valid", {63'd0, o_valid}, 64'd1);
        chk("bp_head",  {31'd0, o_data}, {31'd0, mk(1'b1, 2'd0, 2'd0, 2'd0, 5'd2, 20'd604)});
        chk("bp_held",  {39'd0, o_held}, 64'h0015554);
        repeat (3) step();
        chk("bp_stable", {31'd0, o_data}, {31'd0, mk(1'b1, 2'd0, 2'd0, 2'd0, 5'd2, 20'd604)});
        i_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_word(w, waited);
            chk("bp_drain", {31'd0, w}, {31'd0, mk(1'b1, 2'd0, 2'd0, 2'd0, 5'(2 + 2 * i), 20'd604)});
        end
        chk("bp_notfull", {63'd0, o_full}, 64'd0);
        chk("bp_held_all", {39'd0, o_held}, 64'h0155554);
        i_btn = '0;
        for (int i = 0; i < 10; i++) begin
            wait_word(w, waited);
            chk("bp_off", {31'd0, w}, {31'd0, mk(1'b0, 2'd0, 2'd0, 2'd0, 5'(2 + 2 * i), 20'd604)});
        end

        // Timestamp wraps modulo 2^20
        i_time = 20'hFFFFE; i_wave = 2'd3; i_vol = 2'd3; i_oct = 2'd3;
        i_btn[1] = 1'b1;
        wait_word(w, waited);
        chk("wrap_on", {31'd0, w}, {31'd0, mk(1'b1, 2'd3, 2'd3, 2'd3, 5'd1, 20'h00002)});
        i_btn[1] = 1'b0;
        wait_word(w, waited);
        chk("wrap_off", {31'd0, w}, {31'd0, mk(1'b0, 2'd3, 2'd3, 2'd3, 5'd1, 20'h00002)});

        // One-cycle glitch on button 20 while the scanner is busy with 0..4
        i_time = 20'd700; i_wave = 2'd1; i_vol = 2'd1; i_oct = 2'd1;
        i_btn = 25'h010001F;
        step();
        i_btn = 25'h000001F;
        for (int i = 0; i < 5; i++) begin
            wait_word(w, waited);
            chk("glitch_on", {31'd0, w}, {31'd0, mk(1'b1, 2'd1, 2'd1, 2'd1, 5'(i), 20'd704)});
        end
        repeat (10) step();
        chk("glitch_quiet", {63'd0, o_valid}, 64'd0);
        chk("glitch_held", {39'd0, o_held}, 64'h000001F);

        // Asynchronous reset mid-operation clears queue and held state at once
        i_ready = 1'b0;
        i_btn[9] = 1'b1;
        repeat (5) step();
        chk("mid_pending", {63'd0, o_valid}, 64'd1);
        #2 i_rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, o_valid}, 64'd0);
        chk("mid_rst_held",  {39'd0, o_held}, 64'd0);
        chk("mid_rst_full",  {63'd0, o_full}, 64'd0);
        i_btn = '0;
        repeat (3) step();
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        repeat (6) step();
        chk("post_rst_quiet", {63'd0, o_valid}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/note_event_encoder.md
# note_event_encoder

Producer side of the 33-bit note-event bus consumed by the per-waveform voice generators. Samples 25 note-button levels plus the current wave type, volume and octave selections. Emits one timestamped ON/OFF event word per button state change through a small FIFO with a valid/ready handshake. Each OFF word carries exactly the settings latched at the matching ON, so the receiver always clears the same enable slot it set.

## Interface
- `DEPTH`, 8: FIFO entries (power of two, ≥2).
- `LEAD`, 20'd4: timestamp lead added to `i_time` so the event lands in a future sound-cycle slot.
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_btn`  in  25  debounced note-button levels (1 = held), asynchronous to `i_clk`.
- `i_wave`  in  2  wave-type selection (sine = 2'b11).
- `i_vol`  in  2  volume selection.
- `i_oct`  in  2  octave selection.
- `i_time`  in  20  free-running sound-cycle counter shared with the voice generators.
- `i_panic`  in  1  level; while high, every button target is forced to 0.
- `o_data`  out  33  event word.
- `o_valid`  out  1  `o_data` valid.
- `i_ready`  in  1  consumer accepts when `o_valid && i_ready`.
- `o_held`  out  25  buttons whose last emitted event was ON.
- `o_full`  out  1  FIFO full.

## Operation
- Event word packing:
  - [32] isWave = 1
  - [31] OnOff
  - [30:29] wave
  - [28:27] volume
  - [26:25] octave
  - [24:20] BtnID (0..24)
  - [19:0] timestamp = (`i_time` + `LEAD`) mod 2^20. Wrap is plain modular; no saturation.
- `i_btn` passes through a 2-flop synchronizer, giving `btn_s`.
- Target levels: `tgt` = `i_panic` ? 0 : `btn_s`.
- `sent_on[24:0]` records the last emitted OnOff per button. `o_held` = `sent_on`.
- Mismatch vector: `mis` = `tgt ^ sent_on`.
- Scanner: each cycle where `mis` ≠ 0 and the FIFO is not full, select the lowest-index set bit k and enqueue one word. In the same cycle, toggle `sent_on[k]`.
- ON event (`tgt[k]` = 1):
  - Settings come from the live `i_wave`/`i_vol`/`i_oct`.
  - The 6-bit {wave, vol, oct} is latched into `set_r[k]`.
- OFF event: settings come from `set_r[k]`, not the live inputs. Changing the selectors while a note is held must not change its OFF word.
- A press and release both shorter than the scanner's service time produce no events. The scanner tracks the level, not edges.
- FIFO full: the scanner stalls and `mis` stays set, so no event is lost. Events resume in index order when space frees.
- At most one enqueue and one dequeue per cycle. Simultaneous enqueue and dequeue when full is allowed.

## Timing
- Reset values (all of these):
  - `o_valid` = 0, `o_data` = 0, `o_full` = 0, `o_held` = 0
  - `sent_on` = 0, `set_r` = 0, FIFO empty, synchronizer flops 0.
- Input-to-output latency, empty FIFO: a change of `i_btn` at edge n gives `btn_s` at n+2, enqueue at n+3, and `o_valid` high with the word at n+4. The timestamp is sampled from `i_time` in the enqueue cycle.
- `o_data` is a registered FIFO head. It holds stable while `o_valid && !i_ready`, and advances one cycle after acceptance.
- `o_valid` never drops without a handshake.
- Throughput: one event per cycle sustained while `i_ready` = 1.
- Asserting `i_panic` emits OFF events for all held buttons, lowest index first, one per cycle, subject to FIFO space.
- Reset mid-operation clears the FIFO and `sent_on` immediately. No OFF events are generated for notes the consumer still holds; the system resets the consumer on the same reset.

## Structure
- Package `wave_pkg`:
  - field widths and bit positions of the event word
  - `WAVE_SIN`/other wave-type constants
  - `NUM_BTN` = 25
  - a packed struct `note_evt_t` with a pack function.
- Sub-module `event_fifo`: parameterized DEPTH × 33-bit synchronous FIFO with registered head output, valid/ready out, full flag.
- Scanner, `sent_on`/`set_r` storage and synchronizer live in the top.

## Test plan
- Press button 5 with wave=3, vol=1, oct=2, `i_time`=100, `i_ready`=1 → after 4 cycles `o_data`={1,1,2'b11,2'b01,2'b10,5'd5,20'd104}; `o_held[5]`=1.
- Hold 5, change vol to 3, release → OFF word carries vol=1, oct=2, OnOff=0; `o_held[5]`=0.
- Press buttons 0, 7, 24 in the same cycle → three words in order 0, 7, 24 on consecutive cycles.
- `i_ready`=0, press 10 buttons with `DEPTH`=8 → `o_full`=1 after 8 enqueues, `o_data` stable. Then raise `i_ready` → all 10 events delivered, none lost, ascending order.
- Hold 3 buttons, assert `i_panic` → three OFF words, `o_held`=0. Buttons still held after `i_panic` deasserts → three ON words re-issued.
- `i_time`=20'hFFFFE, press button 1 → timestamp 20'h00002; a 1-cycle glitch on `i_btn` → no event.
